// File: rtl/sound_arbiter_if.sv
// Sound arbiter bus: request/enable from the game logic, tone status back.
//   master : drives enable, req; observes buzzer, busy, grant, active_id
//   slave  : the arbiter itself
interface sound_arbiter_if;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;

    logic                enable;     // low mutes and flushes the arbiter
    logic [NUM_SRC-1:0]  req;        // one-cycle request pulses
    logic                buzzer;     // square-wave buzzer drive
    logic                busy;       // tone or gap in progress
    logic [NUM_SRC-1:0]  grant;      // one-hot pulse at tone start
    logic [ID_W-1:0]     active_id;  // source of the current/last tone

    modport master (
        output enable, req,
        input  buzzer, busy, grant, active_id
    );

    modport slave (
        input  enable, req,
        output buzzer, busy, grant, active_id
    );
endinterface

// File: rtl/sound_arbiter.sv
// sound_arbiter: fixed-priority arbiter for four tone sources (score, paddle,
// wall, menu) driving one buzzer with a square wave, followed by a silent gap.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   bus    : sound_arbiter_if.slave (enable, req in; buzzer, busy, grant,
//            active_id out, all registered)
// Optional feature: define SOUND_PREEMPT_EN to let a higher-priority request
// abort the tone in progress and start immediately.
module sound_arbiter #(
    parameter int unsigned DUR_SCORE   = 6000,
    parameter int unsigned DUR_PADDLE  = 1500,
    parameter int unsigned DUR_WALL    = 1000,
    parameter int unsigned DUR_MENU    = 600,
    parameter int unsigned HALF_SCORE  = 24,
    parameter int unsigned HALF_PADDLE = 12,
    parameter int unsigned HALF_WALL   = 16,
    parameter int unsigned HALF_MENU   = 8,
    parameter int unsigned GAP_CYCLES  = 50
) (
    input  logic                  clk,
    input  logic                  reset,
    sound_arbiter_if.slave        bus
);
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Counters run N-1 .. 0, so a zero parameter behaves like 1
    localparam logic [CNT_W-1:0] LD_DUR_SCORE   = CNT_W'((DUR_SCORE   == 0) ? 0 : DUR_SCORE   - 1);
    localparam logic [CNT_W-1:0] LD_DUR_PADDLE  = CNT_W'((DUR_PADDLE  == 0) ? 0 : DUR_PADDLE  - 1);
    localparam logic [CNT_W-1:0] LD_DUR_WALL    = CNT_W'((DUR_WALL    == 0) ? 0 : DUR_WALL    - 1);
    localparam logic [CNT_W-1:0] LD_DUR_MENU    = CNT_W'((DUR_MENU    == 0) ? 0 : DUR_MENU    - 1);
    localparam logic [CNT_W-1:0] LD_HALF_SCORE  = CNT_W'((HALF_SCORE  == 0) ? 0 : HALF_SCORE  - 1);
    localparam logic [CNT_W-1:0] LD_HALF_PADDLE = CNT_W'((HALF_PADDLE == 0) ? 0 : HALF_PADDLE - 1);
    localparam logic [CNT_W-1:0] LD_HALF_WALL   = CNT_W'((HALF_WALL   == 0) ? 0 : HALF_WALL   - 1);
    localparam logic [CNT_W-1:0] LD_HALF_MENU   = CNT_W'((HALF_MENU   == 0) ? 0 : HALF_MENU   - 1);
    localparam logic [CNT_W-1:0] LD_GAP         = CNT_W'((GAP_CYCLES  == 0) ? 0 : GAP_CYCLES  - 1);

    function automatic logic [CNT_W-1:0] dur_load(input logic [1:0] id);
        case (id)
            2'd3:    dur_load = LD_DUR_SCORE;
            2'd2:    dur_load = LD_DUR_PADDLE;
            2'd1:    dur_load = LD_DUR_WALL;
            default: dur_load = LD_DUR_MENU;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] half_load(input logic [1:0] id);
        case (id)
            2'd3:    half_load = LD_HALF_SCORE;
            2'd2:    half_load = LD_HALF_PADDLE;
            2'd1:    half_load = LD_HALF_WALL;
            default: half_load = LD_HALF_MENU;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             buzzer_q, buzzer_d;
    logic             busy_q, busy_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       id_q, id_d;

    logic [1:0]       hi_idx;
    logic             hi_vld;
    logic             preempt;
    logic             start;
    logic [3:0]       clr;

    // Highest pending index; ascending scan so the top bit wins
    always_comb begin
        hi_vld = |pend_q;
        hi_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (pend_q[i]) hi_idx = 2'(i);
        end
    end

`ifdef SOUND_PREEMPT_EN
    assign preempt = (state_q == ST_PLAY) && hi_vld && (hi_idx > id_q);
`else
    assign preempt = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        dur_d    = dur_q;
        half_d   = half_q;
        buzzer_d = buzzer_q;
        grant_d  = '0;
        id_d     = id_q;
        start    = 1'b0;
        clr      = '0;

        if (!bus.enable) begin
            state_d  = ST_IDLE;
            pend_d   = '0;
            dur_d    = '0;
            half_d   = '0;
            buzzer_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start = hi_vld;
                end
                ST_PLAY: begin
                    if (preempt) begin
                        start = 1'b1;
                    end else if (dur_q == '0) begin
                        state_d  = ST_GAP;
                        dur_d    = LD_GAP;
                        half_d   = '0;
                        buzzer_d = 1'b0;
                    end else begin
                        dur_d = dur_q - CNT_W'(1);
                        if (half_q == '0) begin
                            buzzer_d = ~buzzer_q;
                            half_d   = half_load(id_q);
                        end else begin
                            half_d = half_q - CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (dur_q == '0) state_d = ST_IDLE;
                    else             dur_d   = dur_q - CNT_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase

            if (start) begin
                state_d         = ST_PLAY;
                id_d            = hi_idx;
                grant_d[hi_idx] = 1'b1;
                clr[hi_idx]     = 1'b1;
                dur_d           = dur_load(hi_idx);
                half_d          = half_load(hi_idx);
                buzzer_d        = 1'b1;
            end

            // A same-cycle request for the granted source survives the clear
            pend_d = (pend_q & ~clr) | bus.req;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            dur_q    <= '0;
            half_q   <= '0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
            grant_q  <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            dur_q    <= dur_d;
            half_q   <= half_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
            grant_q  <= grant_d;
            id_q     <= id_d;
        end
    end

    assign bus.buzzer    = buzzer_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = grant_q;
    assign bus.active_id = id_q;

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DUR_SCORE, default 6000, SHALL set the score tone length in clk cycles.
REQ-003 Parameter DUR_PADDLE, default 1500, SHALL set the paddle tone length in clk cycles.
REQ-004 Parameter DUR_WALL, default 1000, SHALL set the wall tone length in clk cycles.
REQ-005 Parameter DUR_MENU, default 600, SHALL set the menu tone length in clk cycles.
REQ-006 Parameter HALF_SCORE / HALF_PADDLE / HALF_WALL / HALF_MENU, defaults 24 / 12 / 16 / 8, SHALL set the buzzer half-period in clk cycles for each source.
REQ-007 Parameter GAP_CYCLES, default 50, SHALL set the silent gap after each tone.
REQ-008 clk  input  1  system clock.
REQ-009 reset  input  1  asynchronous reset, active-low.
REQ-010 enable  input  1  sound enable; low mutes the block and flushes it.
REQ-011 req  input  4  one-cycle request pulses: [3] score, [2] paddle, [1] wall, [0] menu.
REQ-012 buzzer  output  1  square-wave drive to the buzzer pin.
REQ-013 busy  output  1  high while the state is PLAY or GAP.
REQ-014 grant  output  4  one-hot, one-cycle pulse that marks the source starting a tone.
REQ-015 active_id  output  2  index of the source currently playing; holds its last value otherwise.

Function
REQ-016 pending[3:0] SHALL latch: pending[i] is set one edge after req[i] is sampled high. Repeated requests from the same source SHALL merge into one.
REQ-017 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-018 IDLE: if pending is nonzero, the next edge SHALL move to PLAY, grant the highest pending index (fixed priority 3>2>1>0), clear that pending bit, and pulse grant.
REQ-019 Latency: a req pulse sampled at edge k SHALL give grant and buzzer=1 after edge k+1.
REQ-020 PLAY SHALL last exactly DUR_x cycles. buzzer SHALL start at 1 and toggle every HALF_x cycles.
REQ-021 PLAY SHALL then go to GAP for exactly GAP_CYCLES cycles with buzzer=0, then return to IDLE.
REQ-022 A req for the source being granted in the same cycle as its grant SHALL leave its pending bit set, so it replays.
REQ-023 Requests arriving during PLAY or GAP SHALL only set pending bits; without preemption they never affect the current tone.
REQ-024 If enable is low on an edge, the next state SHALL be IDLE, with pending=0, buzzer=0 and grant=0. req SHALL be ignored while enable is low.
REQ-025 Duration and half-period counters SHALL be 16 bits and count down. A parameter value of 0 SHALL be treated as 1.
REQ-026 buzzer SHALL be registered (glitch-free) and SHALL be 0 in IDLE and GAP.

Reset
REQ-027 While reset is low: state=IDLE, pending=0, buzzer=0, busy=0, grant=0, active_id=0, all counters 0.
REQ-028 A reset asserted mid-tone SHALL silence buzzer immediately (asynchronously). After release, no tone SHALL resume.

Configuration
REQ-029 Macro SOUND_PREEMPT_EN defined: in PLAY, a pending index higher than active_id SHALL abort the current tone. The next edge SHALL grant the higher source and enter PLAY directly, with no GAP. The aborted source SHALL NOT be replayed.
REQ-030 Macro SOUND_PREEMPT_EN undefined: no preemption. Tones always complete, per REQ-023.

Verification
REQ-031 req=0100 for one cycle, all other inputs idle -> grant=0100 after edge k+1, buzzer toggles every 12 cycles for 1500 cycles, 50 cycles silent, then IDLE.
REQ-032 req=0011 in the same cycle -> wall tone (1000 cycles) then GAP, then menu tone (600 cycles). grant pulses 0010 then 0001.
REQ-033 A score request 200 cycles into a paddle tone, macro off -> the paddle tone runs its full 1500 cycles, then GAP, then the score tone. Macro on -> the next edge grants 1000 and the paddle tone is not replayed.
REQ-034 enable dropped for 1 cycle mid-tone with wall pending -> buzzer=0 and state IDLE the next cycle, pending=0, no later grant.
REQ-035 reset pulsed low mid-tone -> buzzer=0 within the same cycle, and all outputs at their reset values after release.
REQ-036 req[1] pulsed three times during one wall tone -> exactly one extra wall tone plays after the GAP.
